// File: rtl/seq_packet_unpacker_if.sv
// Sequence packet bus as seen by the unpacker: packet input side (i_*), sequence
// output side (o_*). The master modport is the environment driving packets and sinking beats.
`timescale 1ns/1ps
interface seq_packet_unpacker_if #(
  parameter int CNT_BITS        = 16,
  parameter int SEQ_PACKET_SIZE = 4,
  parameter int SEQ_LL_BITS     = 8,
  parameter int SEQ_ML_BITS     = 8,
  parameter int SEQ_OFFSET_BITS = 16
);
  logic                                     i_valid;
  logic [SEQ_PACKET_SIZE-1:0]               i_mask;
  logic [SEQ_LL_BITS*SEQ_PACKET_SIZE-1:0]   i_ll;
  logic [SEQ_ML_BITS*SEQ_PACKET_SIZE-1:0]   i_ml;
  logic [SEQ_OFFSET_BITS*SEQ_PACKET_SIZE-1:0] i_offset;
  logic [SEQ_ML_BITS-1:0]                   i_overlap;
  logic                                     i_eoj;
  logic                                     i_delim;
  logic                                     i_ready;

  logic                                     o_valid;
  logic [SEQ_LL_BITS-1:0]                   o_ll;
  logic [SEQ_ML_BITS-1:0]                   o_ml;
  logic [SEQ_OFFSET_BITS-1:0]               o_offset;
  logic                                     o_null;
  logic                                     o_last;
  logic [SEQ_ML_BITS-1:0]                   o_overlap;
  logic                                     o_eoj;
  logic                                     o_delim;
  logic [CNT_BITS-1:0]                      o_job_seq_cnt;
  logic                                     o_ready;

  modport master (
    output i_valid, i_mask, i_ll, i_ml, i_offset, i_overlap, i_eoj, i_delim, o_ready,
    input  i_ready, o_valid, o_ll, o_ml, o_offset, o_null, o_last, o_overlap,
           o_eoj, o_delim, o_job_seq_cnt
  );

  modport slave (
    input  i_valid, i_mask, i_ll, i_ml, i_offset, i_overlap, i_eoj, i_delim, o_ready,
    output i_ready, o_valid, o_ll, o_ml, o_offset, o_null, o_last, o_overlap,
           o_eoj, o_delim, o_job_seq_cnt
  );
endinterface

// File: rtl/seq_packet_unpacker.sv
// Sink of the sequence packet bus: buffers one multi-lane packet and emits its
// lanes one per beat in ascending order, tracking the per-job sequence count.
`timescale 1ns/1ps
module seq_packet_unpacker #(
  parameter int CNT_BITS        = 16,
  parameter int SEQ_PACKET_SIZE = 4,
  parameter int SEQ_LL_BITS     = 8,
  parameter int SEQ_ML_BITS     = 8,
  parameter int SEQ_OFFSET_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_packet_unpacker_if.slave bus
);
  localparam int P    = SEQ_PACKET_SIZE;
  localparam int LLW  = SEQ_LL_BITS;
  localparam int MLW  = SEQ_ML_BITS;
  localparam int OFFW = SEQ_OFFSET_BITS;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [P-1:0]        rem_q, rem_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic [LLW*P-1:0]    llBuf_q;
  logic [MLW*P-1:0]    mlBuf_q;
  logic [OFFW*P-1:0]   offBuf_q;
  logic [MLW-1:0]      overlap_q;
  logic                eoj_q;
  logic                delim_q;
  logic                null_q;

  logic [P-1:0]        laneSel;
  logic [LLW-1:0]      laneLl;
  logic [MLW-1:0]      laneMl;
  logic [OFFW-1:0]     laneOff;
  logic                multiBits;
  logic                isLast;
  logic                outValid;
  logic                take;
  logic                nonNull;
  logic                accept;
  logic                skipPkt;
  logic                loadPkt;

  // Lowest set bit of rem wins: the descending scan leaves the lowest lane last.
  always_comb begin
    laneSel = '0;
    laneLl  = '0;
    laneMl  = '0;
    laneOff = '0;
    for (int k = P-1; k >= 0; k--) begin
      if (rem_q[k]) begin
        laneSel    = '0;
        laneSel[k] = 1'b1;
        laneLl     = llBuf_q[k*LLW +: LLW];
        laneMl     = mlBuf_q[k*MLW +: MLW];
        laneOff    = offBuf_q[k*OFFW +: OFFW];
      end
    end
  end

  assign multiBits = |(rem_q & (rem_q - P'(1)));
  assign isLast    = null_q || !multiBits;
  assign outValid  = rst_n && (state_q == DRAIN);
  assign take      = outValid && bus.o_ready;
  assign nonNull   = outValid && !null_q;

  // Refill in the same cycle the last beat leaves, so single-lane packets stream.
  assign bus.i_ready = rst_n && ((state_q == EMPTY) || (take && isLast));
  assign accept      = bus.i_valid && bus.i_ready;
  assign skipPkt     = (bus.i_mask == '0) && !bus.i_eoj && !bus.i_delim;
  assign loadPkt     = accept && !skipPkt;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    if (take) begin
      rem_d = rem_q & ~laneSel;
      if (isLast && eoj_q) begin
        cnt_d = '0;
      end else if (!null_q) begin
        cnt_d = cnt_q + CNT_BITS'(1);
      end
      if (isLast) begin
        state_d = EMPTY;
      end
    end
    if (accept) begin
      rem_d   = bus.i_mask;
      state_d = skipPkt ? EMPTY : DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      llBuf_q   <= '0;
      mlBuf_q   <= '0;
      offBuf_q  <= '0;
      overlap_q <= '0;
      eoj_q     <= 1'b0;
      delim_q   <= 1'b0;
      null_q    <= 1'b0;
    end else if (loadPkt) begin
      llBuf_q   <= bus.i_ll;
      mlBuf_q   <= bus.i_ml;
      offBuf_q  <= bus.i_offset;
      overlap_q <= bus.i_overlap;
      eoj_q     <= bus.i_eoj;
      delim_q   <= bus.i_delim;
      null_q    <= (bus.i_mask == '0);
    end
  end

  // Packet-level flags only appear on the final beat; lane data is zero on null beats.
  assign bus.o_valid       = outValid;
  assign bus.o_ll          = nonNull ? laneLl  : '0;
  assign bus.o_ml          = nonNull ? laneMl  : '0;
  assign bus.o_offset      = nonNull ? laneOff : '0;
  assign bus.o_null        = outValid && null_q;
  assign bus.o_last        = outValid && isLast;
  assign bus.o_overlap     = (outValid && isLast) ? overlap_q : '0;
  assign bus.o_eoj         = outValid && isLast && eoj_q;
  assign bus.o_delim       = outValid && isLast && delim_q;
  assign bus.o_job_seq_cnt = cnt_q + CNT_BITS'(nonNull);
endmodule

// File: tb/tb_seq_packet_unpacker.sv
// Scoreboard bench for seq_packet_unpacker: the driver queues expected beats per packet,
// and a negedge monitor compares every presented beat and the ready/valid handshake.
`timescale 1ns/1ps
module tb_seq_packet_unpacker;
  localparam int P    = 4;
  localparam int LLW  = 8;
  localparam int MLW  = 8;
  localparam int OFFW = 16;
  localparam int CNTW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_packet_unpacker_if #(
    .CNT_BITS(CNTW), .SEQ_PACKET_SIZE(P), .SEQ_LL_BITS(LLW),
    .SEQ_ML_BITS(MLW), .SEQ_OFFSET_BITS(OFFW)
  ) bus ();

  seq_packet_unpacker #(
    .CNT_BITS(CNTW), .SEQ_PACKET_SIZE(P), .SEQ_LL_BITS(LLW),
    .SEQ_ML_BITS(MLW), .SEQ_OFFSET_BITS(OFFW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [LLW-1:0]  ll;
    logic [MLW-1:0]  ml;
    logic [OFFW-1:0] off;
    logic            nul;
    logic            last;
    logic [MLW-1:0]  ovl;
    logic            eoj;
    logic            delim;
    logic [CNTW-1:0] cnt;
  } beat_t;

  beat_t           expQ[$];
  logic [CNTW-1:0] expCnt = '0;
  int              compared = 0;
  int              mismatched = 0;
  int              runLen = 0;
  int              maxRun = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Queue the beats a packet should produce, then hold it on the bus until accepted.
  task automatic applyStimulus(input logic [P-1:0] mask, input logic [LLW*P-1:0] ll,
                               input logic [MLW*P-1:0] ml, input logic [OFFW*P-1:0] off,
                               input logic [MLW-1:0] ovl, input logic eoj, input logic delim);
    beat_t b;
    int    lastLane;
    bit    accepted;
    lastLane = -1;
    for (int k = 0; k < P; k++) if (mask[k]) lastLane = k;
    if (mask == '0) begin
      if (eoj || delim) begin
        b.ll = '0; b.ml = '0; b.off = '0;
        b.nul = 1'b1; b.last = 1'b1; b.ovl = ovl; b.eoj = eoj; b.delim = delim;
        b.cnt = expCnt;
        expQ.push_back(b);
        if (eoj) expCnt = '0;
      end
    end else begin
      for (int k = 0; k < P; k++) begin
        if (mask[k]) begin
          b.ll    = ll[k*LLW +: LLW];
          b.ml    = ml[k*MLW +: MLW];
          b.off   = off[k*OFFW +: OFFW];
          b.nul   = 1'b0;
          b.last  = (k == lastLane);
          b.ovl   = b.last ? ovl : '0;
          b.eoj   = b.last && eoj;
          b.delim = b.last && delim;
          b.cnt   = expCnt + 16'd1;
          expQ.push_back(b);
          if (b.eoj) expCnt = '0;
          else       expCnt = expCnt + 16'd1;
        end
      end
    end
    bus.i_mask    = mask;
    bus.i_ll      = ll;
    bus.i_ml      = ml;
    bus.i_offset  = off;
    bus.i_overlap = ovl;
    bus.i_eoj     = eoj;
    bus.i_delim   = delim;
    bus.i_valid   = 1'b1;
    accepted = 1'b0;
    for (int c = 0; c < 100 && !accepted; c++) begin
      @(negedge clk);
      if (bus.i_ready) begin
        @(posedge clk);
        #1;
        accepted = 1'b1;
      end
    end
    bus.i_valid = 1'b0;
    if (!accepted) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: got i_ready=0 for 100 cycles, expected accept");
    end
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (expQ.size() == 0) done = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout: got %0d beats pending, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      checkOutput("o_valid_in_reset", 32'(bus.o_valid), 0);
      checkOutput("i_ready_in_reset", 32'(bus.i_ready), 0);
      runLen = 0;
    end else if (bus.o_valid) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_beat: got o_valid=1 o_ll=%0d, expected no beat", bus.o_ll);
      end else begin
        e = expQ[0];
        checkOutput("o_ll",          32'(bus.o_ll),          32'(e.ll));
        checkOutput("o_ml",          32'(bus.o_ml),          32'(e.ml));
        checkOutput("o_offset",      32'(bus.o_offset),      32'(e.off));
        checkOutput("o_null",        32'(bus.o_null),        32'(e.nul));
        checkOutput("o_last",        32'(bus.o_last),        32'(e.last));
        checkOutput("o_overlap",     32'(bus.o_overlap),     32'(e.ovl));
        checkOutput("o_eoj",         32'(bus.o_eoj),         32'(e.eoj));
        checkOutput("o_delim",       32'(bus.o_delim),       32'(e.delim));
        checkOutput("o_job_seq_cnt", 32'(bus.o_job_seq_cnt), 32'(e.cnt));
        checkOutput("i_ready_busy",  32'(bus.i_ready),       32'(bus.o_ready && e.last));
        if (bus.o_ready) begin
          void'(expQ.pop_front());
          runLen++;
          if (runLen > maxRun) maxRun = runLen;
        end else begin
          runLen = 0;
        end
      end
    end else begin
      checkOutput("i_ready_idle", 32'(bus.i_ready), 1);
      runLen = 0;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish by 400us, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [LLW*P-1:0]  llv;
    logic [MLW*P-1:0]  mlv;
    logic [OFFW*P-1:0] offv;
    logic [P-1:0]      mask;
    int                lane;

    bus.i_valid = 1'b0; bus.i_mask = '0; bus.i_ll = '0; bus.i_ml = '0;
    bus.i_offset = '0; bus.i_overlap = '0; bus.i_eoj = 1'b0; bus.i_delim = 1'b0;
    bus.o_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_o_ll",  32'(bus.o_ll), 0);
    checkOutput("reset_cnt",   32'(bus.o_job_seq_cnt), 0);
    checkOutput("reset_last",  32'(bus.o_last), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] multi-lane packet");
    applyStimulus(4'b1011, {8'd40, 8'd30, 8'd20, 8'd10}, {8'd6, 8'd5, 8'd4, 8'd3},
                  {16'd400, 16'd300, 16'd200, 16'd100}, 8'd0, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] backpressure on beat 2");
    applyStimulus(4'b1011, {8'd40, 8'd30, 8'd20, 8'd10}, {8'd6, 8'd5, 8'd4, 8'd3},
                  {16'd400, 16'd300, 16'd200, 16'd100}, 8'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.o_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.o_ready = 1'b1;
    waitDrain();

    $display("[TB] null packet closing a 7-sequence job");
    applyStimulus(4'b0001, {8'd0, 8'd0, 8'd0, 8'd77}, {8'd0, 8'd0, 8'd0, 8'd9},
                  {16'd0, 16'd0, 16'd0, 16'd700}, 8'd0, 1'b0, 1'b0);
    applyStimulus(4'b0000, '0, '0, '0, 8'd0, 1'b1, 1'b1);
    applyStimulus(4'b0100, {8'd0, 8'd55, 8'd0, 8'd0}, {8'd0, 8'd8, 8'd0, 8'd0},
                  {16'd0, 16'd550, 16'd0, 16'd0}, 8'd0, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] skipped packet");
    applyStimulus(4'b0000, '0, '0, '0, 8'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(4'b0010, {8'd0, 8'd0, 8'd66, 8'd0}, {8'd0, 8'd0, 8'd7, 8'd0},
                  {16'd0, 16'd0, 16'd660, 16'd0}, 8'd0, 1'b1, 1'b0);
    waitDrain();

    $display("[TB] streaming single-lane packets");
    repeat (3) @(posedge clk);
    #1;
    maxRun = 0;
    for (int i = 0; i < 16; i++) begin
      lane = i % P;
      mask = '0;
      mask[lane] = 1'b1;
      llv = '0; mlv = '0; offv = '0;
      llv[lane*LLW +: LLW]    = LLW'(i + 1);
      mlv[lane*MLW +: MLW]    = MLW'(i + 2);
      offv[lane*OFFW +: OFFW] = OFFW'(100 * (i + 1));
      applyStimulus(mask, llv, mlv, offv, (i == 15) ? 8'd5 : 8'd0, i == 15, 1'b0);
    end
    waitDrain();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("stream_consecutive_beats", 32'(maxRun), 16);

    $display("[TB] reset mid-drain");
    applyStimulus(4'b1111, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd4, 8'd3, 8'd2, 8'd1},
                  {16'd4, 16'd3, 16'd2, 16'd1}, 8'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    expQ.delete();
    expCnt = '0;
    @(posedge clk);
    #1;
    checkOutput("midrst_o_valid", 32'(bus.o_valid), 0);
    checkOutput("midrst_cnt",     32'(bus.o_job_seq_cnt), 0);
    checkOutput("midrst_o_ll",    32'(bus.o_ll), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(4'b0001, {8'd0, 8'd0, 8'd0, 8'd99}, {8'd0, 8'd0, 8'd0, 8'd11},
                  {16'd0, 16'd0, 16'd0, 16'd990}, 8'd0, 1'b1, 1'b0);
    waitDrain();

    checkOutput("scoreboard_empty", 32'(expQ.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/seq_packet_unpacker.md
# seq_packet_unpacker

Sink end of the sequence packet bus. It sits after the last bus node and accepts multi-lane sequence packets: mask, per-lane ll/ml/offset, overlap, eoj and delim. It serializes each packet into one sequence per beat, in ascending lane order, for the downstream sequence encoder. It also keeps a per-job sequence count, which is reported on the job's final beat.

## Interface

Parameters:
- CNT_BITS, default 16: width of the per-job sequence counter.
- Lane widths come from parameters.vh: SEQ_PACKET_SIZE (P), SEQ_LL_BITS, SEQ_ML_BITS, SEQ_OFFSET_BITS.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_valid  in  1  packet valid
- i_mask  in  P  lane-valid bits
- i_ll  in  SEQ_LL_BITS*P  literal lengths; lane k at [k*W +: W]
- i_ml  in  SEQ_ML_BITS*P  match lengths
- i_offset  in  SEQ_OFFSET_BITS*P  offsets
- i_overlap  in  SEQ_ML_BITS  packet overlap
- i_eoj  in  1  end of job
- i_delim  in  1  delimiter
- i_ready  out  1  packet accept
- o_valid  out  1  sequence beat valid
- o_ll  out  SEQ_LL_BITS  lane literal length
- o_ml  out  SEQ_ML_BITS  lane match length
- o_offset  out  SEQ_OFFSET_BITS  lane offset
- o_null  out  1  beat carries no sequence (flag-only beat)
- o_last  out  1  final beat of the packet
- o_overlap  out  SEQ_ML_BITS  packet overlap; meaningful only when o_last=1, else 0
- o_eoj  out  1  i_eoj of packet, only on the o_last beat
- o_delim  out  1  i_delim of packet, only on the o_last beat
- o_job_seq_cnt  out  CNT_BITS  count of non-null beats in the job including this one; meaningful when o_eoj=1
- o_ready  in  1  downstream accept

## Operation

Storage:
- One packet buffer holding all fields of the packet.
- A remaining-mask register rem.

States:
- EMPTY: buffer is empty.
- DRAIN: buffer is full.

Accepting a packet:
- i_ready = (state==EMPTY) || (o_valid && o_ready && o_last).
- On accept, the packet is stored and rem <= i_mask.

Skipped packets:
- If i_mask==0 and i_eoj==0 and i_delim==0, the packet is discarded on accept.
- The state stays EMPTY, or goes to EMPTY if the accept came from DRAIN.

Null packets:
- If i_mask==0 and (i_eoj or i_delim), the packet is stored with a null flag.
- It produces exactly one beat: o_null=1, o_last=1, and o_ll/o_ml/o_offset all 0.

Normal beats:
- Each beat presents the lowest set bit k of rem.
- o_last = (rem has exactly one bit set).
- On o_valid && o_ready: rem clears bit k; the counter increments if the beat is non-null.
- When the o_last beat is taken, state goes to EMPTY unless a new packet is accepted in the same cycle, in which case it stays in DRAIN.

Job counter:
- cnt resets to 0.
- o_job_seq_cnt = cnt + (non-null beat ? 1 : 0).
- When a beat with o_eoj is taken, cnt <= 0. Otherwise, when a non-null beat is taken, cnt <= cnt+1.
- Counter width is CNT_BITS; it wraps modulo 2^CNT_BITS, and wrap is not flagged.

Other rules:
- Output fields are held stable while o_valid && !o_ready.
- o_overlap, o_eoj and o_delim are 0 on non-last beats.

## Timing

Latency:
- o_valid rises in the cycle after the packet is accepted.
- Acceptance has no combinational path from i_valid to o_valid.

Throughput:
- One beat per cycle.
- A packet with n set mask bits occupies the output for n cycles.
- Single-lane packets stream back-to-back at 1 packet/cycle, using the same-cycle refill path.

Combinational paths:
- i_ready depends combinationally on o_ready (same-cycle refill). The upstream bus node already expects ready to depend on downstream ready.

Reset (rst_n=0 at posedge clk):
- State goes to EMPTY, and rem=0, cnt=0.
- o_valid=0 and i_ready=0 while rst_n is low.
- All data outputs are 0 after reset.
- Reset mid-DRAIN drops the buffered packet with no partial output.

Simultaneous events:
- Last-beat take and new accept in the same cycle: the new packet is loaded and the counter update from the taken beat still applies.
- If the new packet is a skipped (all-zero) packet, the state goes to EMPTY.

## Test plan

Examples assume P≥4.

- **Multi-lane packet:** mask=4'b1011, ll={40,30,20,10}, eoj=0, o_ready=1. Expect 3 beats with ll 10,20,40. o_last only on the 3rd beat; o_null=0 throughout. i_ready=1 in the 3rd beat's cycle.
- **Backpressure:** same packet with o_ready low for 5 cycles on beat 2. Beat 2 fields are held stable, i_ready=0 during the stall, and no beat is lost or duplicated.
- **Null packet:** mask=0, eoj=1, delim=1 after a job of 7 sequences. Expect one beat with o_null=1, o_last=1, o_eoj=1, o_delim=1, o_job_seq_cnt=7. The next job's count starts at 1.
- **Skipped packet:** mask=0, eoj=0, delim=0. No output beat, i_ready stays 1, and the counter is unchanged.
- **Streaming:** 16 back-to-back single-lane packets, last one with eoj and overlap=5. Expect 16 output beats in 16 consecutive cycles. The final beat has o_eoj=1, o_overlap=5, o_job_seq_cnt=16.
- **Reset mid-drain:** assert rst_n=0 mid-drain of a 4-lane packet. Next cycle o_valid=0 and counters are cleared. After release, a fresh 1-lane eoj packet reports o_job_seq_cnt=1.
